// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and WIDTH limits.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_legal(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder assembled from two half adders; the single arithmetic cell
// that the serial sequencer steps across the operands.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s1), .c(c1));
  half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

  // Both half-adder carries can never be high together, so OR is the full carry.
  assign co = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: accept {a,b,cin}, ripple one bit per clock LSB-first
// through a single full adder, then present {cout,sum} until taken.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit, carry_nxt;
  logic             accept, last;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  full_adder u_fa (.x(opa[0]), .y(opb[0]), .ci(carry), .s(s_bit), .co(carry_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == ST_RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= carry_nxt;
      sum   <= {s_bit, sum[WIDTH-1:1]};
      // Park the counter at zero on the final bit rather than letting it wrap.
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) cout <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH = 8: latency, carry ripple,
// backpressure, mid-run reset and back-to-back throughput.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one operand set for exactly one edge; caller guarantees IDLE.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b, want 1 0 0 00 0",
               in_ready, busy, out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_latency();
    out_ready = 1'b1;
    accept_op(8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= W; i++) begin
      if (i < W) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL zero_run_%0d: out_valid=%b busy=%b in_ready=%b, want 0 1 0", i, out_valid, busy, in_ready);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: out_valid=%b sum=%h cout=%b in_ready=%b, want 1 00 0 0", out_valid, sum, cout, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_ripple();
    logic [W-1:0] va [4] = '{8'hFF, 8'hA5, 8'h80, 8'h3C};
    logic [W-1:0] vb [4] = '{8'h01, 8'h5A, 8'h80, 8'h0F};
    logic         vc [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic [W-1:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'h4C};
    logic         ec [4] = '{1'b1,  1'b1,  1'b1,  1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      accept_op(va[k], vb[k], vc[k]);
      for (int i = 0; i < W; i++) tick();
      checks++;
      if (out_valid !== 1'b1 || sum !== es[k] || cout !== ec[k]) begin
        errors++;
        $display("FAIL ripple_%0d: out_valid=%b sum=%h cout=%b, want 1 %h %b", k, out_valid, sum, cout, es[k], ec[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept_op(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < W; i++) tick();
    in_valid = 1'b1; a = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b sum=%h cout=%b in_ready=%b, want 1 46 0 0",
                 i, out_valid, sum, cout, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h46) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h, want 1 0 46", in_ready, out_valid, sum);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    for (int i = 0; i < W; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h33 || cout !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_result: out_valid=%b sum=%h cout=%b, want 1 33 1", out_valid, sum, cout);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen_valid;
    out_ready = 1'b1;
    accept_op(8'h55, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: out_valid=%b sum=%h in_ready=%b busy=%b, want 0 00 1 0",
               out_valid, sum, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    seen_valid = 0;
    accept_op(8'h12, 8'h34, 1'b1);
    for (int i = 1; i < W; i++) begin
      if (out_valid === 1'b1) seen_valid++;
      tick();
    end
    if (out_valid === 1'b1) seen_valid += 0;
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL rst_spurious_valid: early out_valid cycles=%0d, want 0", seen_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h47 || cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_result: out_valid=%b sum=%h cout=%b, want 1 47 0", out_valid, sum, cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2, n;
    logic [W-1:0] s1, s2;
    out_ready = 1'b1;
    a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    t0 = cyc;
    a = 8'h7F; b = 8'h01;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin tick(); n++; end
    t1 = cyc; s1 = sum;
    tick();
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin tick(); n++; end
    t2 = cyc; s2 = sum;
    checks++;
    if (t1 - t0 != W || s1 !== 8'h02) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d sum=%h, want %0d 02", t1 - t0, s1, W);
    end
    checks++;
    if (t2 - t1 != W + 2 || s2 !== 8'h80 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: spacing=%0d sum=%h cout=%b, want %0d 80 0", t2 - t1, s2, cout, W + 2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
